// File: rtl/sync_noc_router.sv
// Synchronous N-port NoC router. Each input has a flit FIFO, routing is table-driven, and each output has a round-robin arbiter.
// A head flit with an illegal route (out of range, or a U-turn on a link port) is discarded and reported on drop_pulse.
module sync_noc_router #(
    parameter int WIDTH         = 12,
    parameter int NUM_PORTS     = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int ADDR_BITS     = 3,
    parameter int SOURCE_ROUTER = 0,
    parameter logic [(2**ADDR_BITS)*$clog2(NUM_PORTS)-1:0] ROUTE_TABLE = 16'h79E4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_PORTS*WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]       in_valid,
    output logic [NUM_PORTS-1:0]       in_ready,
    output logic [NUM_PORTS*WIDTH-1:0] out_data,
    output logic [NUM_PORTS-1:0]       out_valid,
    input  logic [NUM_PORTS-1:0]       out_ready,
    output logic [NUM_PORTS-1:0]       drop_pulse
);
    localparam int PB = $clog2(NUM_PORTS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [ADDR_BITS-1:0] SRC_ADDR = ADDR_BITS'(SOURCE_ROUTER);
    localparam logic [PB:0]          NP       = (PB+1)'(NUM_PORTS);
    localparam logic [CW-1:0]        FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [PB-1:0]        LAST_IDX = PB'(NUM_PORTS - 1);

    logic [NUM_PORTS-1:0] w_push;
    logic [NUM_PORTS-1:0] w_pop;
    logic [NUM_PORTS-1:0] w_drop;
    logic [NUM_PORTS-1:0] w_nonempty;
    logic [NUM_PORTS-1:0] w_legal;
    logic [WIDTH-1:0]     w_head [NUM_PORTS];
    logic [PB:0]          w_tgt [NUM_PORTS];
    logic [PB-1:0]        w_table [2**ADDR_BITS];
    logic [NUM_PORTS-1:0] w_grant_vld;
    logic [PB-1:0]        w_grant_idx [NUM_PORTS];

    logic [PB-1:0]        r_rr [NUM_PORTS];
    logic [WIDTH-1:0]     r_out_data [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_out_valid;
    logic [NUM_PORTS-1:0] r_drop_pulse;

    genvar gi;

    for (gi = 0; gi < 2**ADDR_BITS; gi++) begin : g_tbl
        assign w_table[gi] = ROUTE_TABLE[gi*PB +: PB];
    end

    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_in
        logic [WIDTH-1:0]     r_mem [FIFO_DEPTH];
        logic [AW-1:0]        r_wr_ptr;
        logic [AW-1:0]        r_rd_ptr;
        logic [CW-1:0]        r_count;
        logic [ADDR_BITS-1:0] w_dest;

        assign in_ready[gi]   = !reset && (r_count != FULL_CNT);
        assign w_push[gi]     = in_valid[gi] && in_ready[gi];
        assign w_nonempty[gi] = (r_count != '0);
        // Head is read combinationally so an accepted flit can reach its output on the very next edge.
        assign w_head[gi]     = r_mem[r_rd_ptr];
        assign w_dest         = w_head[gi][ADDR_BITS:1];
        assign w_tgt[gi]      = (w_dest == SRC_ADDR) ? '0 : {1'b0, w_table[w_dest]};
        assign w_legal[gi]    = (w_tgt[gi] < NP) && !((gi != 0) && (w_tgt[gi] == (PB+1)'(gi)));
        assign w_drop[gi]     = w_nonempty[gi] && !w_legal[gi];

        always_ff @(posedge clk) begin
            if (w_push[gi]) begin
                r_mem[r_wr_ptr] <= in_data[gi*WIDTH +: WIDTH];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push[gi]) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop[gi]) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push[gi], w_pop[gi]})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end

        assign out_data[gi*WIDTH +: WIDTH] = r_out_data[gi];
    end

    // A head targets exactly one output, so each input is granted at most once per cycle.
    always_comb begin
        logic [PB:0]   w_sum;
        logic [PB-1:0] w_idx;
        w_sum       = '0;
        w_idx       = '0;
        w_grant_vld = '0;
        w_pop       = w_drop;
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_grant_idx[o] = '0;
            if (!r_out_valid[o] || out_ready[o]) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    w_sum = {1'b0, r_rr[o]} + (PB+1)'(k);
                    if (w_sum >= NP) begin
                        w_sum = w_sum - NP;
                    end
                    w_idx = w_sum[PB-1:0];
                    if (!w_grant_vld[o] && w_nonempty[w_idx] && w_legal[w_idx] &&
                        (w_tgt[w_idx] == (PB+1)'(o))) begin
                        w_grant_vld[o] = 1'b1;
                        w_grant_idx[o] = w_idx;
                        w_pop[w_idx]   = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= '0;
            r_drop_pulse <= '0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                r_out_data[o] <= '0;
                r_rr[o]       <= '0;
            end
        end else begin
            r_drop_pulse <= w_drop;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (w_grant_vld[o]) begin
                    r_out_data[o]  <= w_head[w_grant_idx[o]];
                    r_out_valid[o] <= 1'b1;
                    r_rr[o]        <= (w_grant_idx[o] == LAST_IDX) ? '0 : w_grant_idx[o] + 1'b1;
                end else if (out_ready[o]) begin
                    r_out_valid[o] <= 1'b0;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign drop_pulse = r_drop_pulse;

endmodule

// File: tb/tb_sync_noc_router.sv
// Scoreboard bench for sync_noc_router. Each accepted flit is queued under (source field, expected output).
// The monitor pops that queue and compares when the flit leaves the router.
module tb_sync_noc_router;
    localparam int W = 12;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N*W-1:0] in_data;
    logic [N*W-1:0] out_data;
    logic [N-1:0] in_valid;
    logic [N-1:0] in_ready;
    logic [N-1:0] out_valid;
    logic [N-1:0] out_ready;
    logic [N-1:0] drop_pulse;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] tx_q [N][$];
    logic [W-1:0] sb [N][N][$];
    int out_cnt [N] = '{default: 0};
    int drop_cnt [N] = '{default: 0};
    int grant_log [$];
    int tbl [8] = '{0, 1, 2, 3, 1, 2, 3, 1};

    sync_noc_router #(
        .WIDTH(12), .NUM_PORTS(4), .FIFO_DEPTH(4), .ADDR_BITS(3),
        .SOURCE_ROUTER(0), .ROUTE_TABLE(16'h79E4)
    ) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input int src, input int seq, input int dest);
        return {2'(src), 6'(seq), 3'(dest), 1'b0};
    endfunction

    function automatic int exp_port(input int p, input logic [2:0] dest);
        int t;
        if (dest == 3'd0) return 0;
        t = tbl[dest];
        if (t == p && p != 0) return -1;
        return t;
    endfunction

    function automatic bit busy();
        for (int p = 0; p < N; p++) if (tx_q[p].size() != 0) return 1'b1;
        for (int a = 0; a < N; a++)
            for (int b = 0; b < N; b++)
                if (sb[a][b].size() != 0) return 1'b1;
        return (out_valid != '0);
    endfunction

    // Scoreboard monitor: a transfer happens at the next rising edge when valid and ready are both high.
    always @(negedge clk) begin : mon
        logic [W-1:0] f;
        logic [W-1:0] e;
        int s;
        if (reset === 1'b0) begin
            for (int o = 0; o < N; o++) begin
                if (out_valid[o] && out_ready[o]) begin
                    f = out_data[o*W +: W];
                    s = int'(f[11:10]);
                    n_cmp++;
                    if (sb[s][o].size() == 0) begin
                        n_err++;
                        $display("FAIL sb_unexpected: out%0d got %h, required no flit", o, f);
                    end else begin
                        e = sb[s][o].pop_front();
                        if (f !== e) begin
                            n_err++;
                            $display("FAIL sb_data: out%0d got %h, required %h", o, f, e);
                        end else begin
                            $display("[%0t] out%0d flit %h", $time, o, f);
                        end
                    end
                    out_cnt[o]++;
                    if (o == 2) grant_log.push_back(s);
                end
            end
            for (int i = 0; i < N; i++) if (drop_pulse[i] === 1'b1) drop_cnt[i]++;
        end
    end

    // One clock: record acceptances before the edge, then present the next queued flits after it.
    task automatic cycle();
        logic [W-1:0] f;
        int op;
        @(negedge clk);
        for (int p = 0; p < N; p++) begin
            if (in_valid[p] && in_ready[p]) begin
                f  = in_data[p*W +: W];
                op = exp_port(p, f[3:1]);
                if (op >= 0) sb[f[11:10]][op].push_back(f);
                void'(tx_q[p].pop_front());
            end
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (tx_q[p].size() != 0) begin
                in_valid[p]       = 1'b1;
                in_data[p*W +: W] = tx_q[p][0];
            end else begin
                in_valid[p] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = '0;
        for (int p = 0; p < N; p++) tx_q[p].delete();
        cycle();
        cycle();
        reset = 1'b0;
        for (int a = 0; a < N; a++)
            for (int b = 0; b < N; b++)
                sb[a][b].delete();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (busy() && n < 300) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (busy()) begin
            n_err++;
            $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '1;
        cycle();
        cycle();
        n_cmp++; if (in_ready !== 4'h0) begin n_err++; $display("FAIL rst_in_ready: got %b, required 0000", in_ready); end
        n_cmp++; if (out_valid !== 4'h0) begin n_err++; $display("FAIL rst_out_valid: got %b, required 0000", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL rst_out_data: got %h, required 0", out_data); end
        n_cmp++; if (drop_pulse !== 4'h0) begin n_err++; $display("FAIL rst_drop: got %b, required 0000", drop_pulse); end
        reset = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 4'hF) begin n_err++; $display("FAIL rst_release_ready: got %b, required 1111", in_ready); end
        $display("[%0t] test_reset done", $time);
    endtask

    task automatic test_single();
        do_reset();
        tx_q[1].push_back(12'h0A0);
        cycle();
        cycle();
        n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL single_pre: out_valid %b, required 0000", out_valid); end
        cycle();
        n_cmp++; if (out_valid !== 4'b0001) begin n_err++; $display("FAIL single_valid: out_valid %b, required 0001", out_valid); end
        n_cmp++; if (out_data[11:0] !== 12'h0A0) begin n_err++; $display("FAIL single_data: got %h, required 0a0", out_data[11:0]); end
        drain("single");
        $display("[%0t] test_single done", $time);
    endtask

    task automatic test_contention();
        int rot [3] = '{0, 1, 3};
        int lim;
        do_reset();
        grant_log.delete();
        for (int s = 0; s < 6; s++) begin
            tx_q[0].push_back(mk(0, s, 2));
            tx_q[1].push_back(mk(1, s, 2));
            tx_q[3].push_back(mk(3, s, 2));
        end
        drain("contention");
        n_cmp++;
        if (grant_log.size() != 18) begin
            n_err++;
            $display("FAIL cont_count: got %0d grants, required 18", grant_log.size());
        end
        lim = (grant_log.size() < 18) ? grant_log.size() : 18;
        for (int k = 0; k < lim; k++) begin
            n_cmp++;
            if (grant_log[k] != rot[k % 3]) begin
                n_err++;
                $display("FAIL cont_rr[%0d]: got input %0d, required %0d", k, grant_log[k], rot[k % 3]);
            end
        end
        $display("[%0t] test_contention done", $time);
    endtask

    task automatic test_uturn();
        int d0;
        int seen;
        do_reset();
        d0   = drop_cnt[1];
        seen = 0;
        tx_q[1].push_back(12'h002);
        cycle();
        cycle();
        n_cmp++; if (drop_pulse !== 4'b0000) begin n_err++; $display("FAIL uturn_pre: drop %b, required 0000", drop_pulse); end
        cycle();
        n_cmp++; if (drop_pulse !== 4'b0010) begin n_err++; $display("FAIL uturn_pulse: drop %b, required 0010", drop_pulse); end
        if (out_valid !== 4'b0000) seen++;
        cycle();
        n_cmp++; if (drop_pulse !== 4'b0000) begin n_err++; $display("FAIL uturn_width: drop %b, required 0000", drop_pulse); end
        repeat (4) begin
            cycle();
            if (out_valid !== 4'b0000) seen++;
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL uturn_no_out: %0d cycles with out_valid, required 0", seen); end
        n_cmp++; if (drop_cnt[1] - d0 != 1) begin n_err++; $display("FAIL uturn_count: %0d pulses, required 1", drop_cnt[1] - d0); end
        n_cmp++; if (in_ready[1] !== 1'b1) begin n_err++; $display("FAIL uturn_fifo_empty: in_ready %b, required 1", in_ready[1]); end
        $display("[%0t] test_uturn done", $time);
    endtask

    task automatic test_backpressure();
        int c0;
        int unstable;
        do_reset();
        out_ready = 4'b0111;
        unstable  = 0;
        for (int s = 0; s < 5; s++) tx_q[0].push_back(mk(0, s, 3));
        repeat (10) cycle();
        n_cmp++; if (tx_q[0].size() != 0) begin n_err++; $display("FAIL bp_accepted: %0d flits pending, required 0", tx_q[0].size()); end
        n_cmp++; if (in_ready[0] !== 1'b0) begin n_err++; $display("FAIL bp_ready_low: in_ready %b, required 0", in_ready[0]); end
        n_cmp++; if (out_valid[3] !== 1'b1) begin n_err++; $display("FAIL bp_valid: out_valid[3] %b, required 1", out_valid[3]); end
        repeat (3) begin
            cycle();
            if (out_data[3*W +: W] !== mk(0, 0, 3) || out_valid[3] !== 1'b1 || in_ready[0] !== 1'b0) unstable++;
        end
        n_cmp++; if (unstable != 0) begin n_err++; $display("FAIL bp_hold: %0d unstable cycles, out3 %h, required %h held", unstable, out_data[3*W +: W], mk(0, 0, 3)); end
        c0 = out_cnt[3];
        out_ready = 4'b1111;
        drain("bp");
        n_cmp++; if (out_cnt[3] - c0 != 5) begin n_err++; $display("FAIL bp_count: %0d flits, required 5", out_cnt[3] - c0); end
        $display("[%0t] test_backpressure done", $time);
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        seen      = 0;
        out_ready = 4'b1011;
        for (int s = 0; s < 4; s++) tx_q[0].push_back(mk(0, s, 2));
        repeat (8) cycle();
        n_cmp++; if (out_valid[2] !== 1'b1) begin n_err++; $display("FAIL rm_pre_valid: out_valid[2] %b, required 1", out_valid[2]); end
        reset    = 1'b1;
        in_valid = '0;
        for (int p = 0; p < N; p++) tx_q[p].delete();
        #1;
        n_cmp++; if (in_ready !== 4'h0) begin n_err++; $display("FAIL rm_ready_low: in_ready %b, required 0000", in_ready); end
        cycle();
        n_cmp++; if (out_valid !== 4'h0) begin n_err++; $display("FAIL rm_valid_clear: out_valid %b, required 0000", out_valid); end
        n_cmp++; if (in_ready !== 4'h0) begin n_err++; $display("FAIL rm_ready_hold: in_ready %b, required 0000", in_ready); end
        reset = 1'b0;
        for (int a = 0; a < N; a++)
            for (int b = 0; b < N; b++)
                sb[a][b].delete();
        out_ready = '1;
        repeat (10) begin
            cycle();
            if (out_valid !== 4'h0) seen++;
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rm_stale: %0d cycles with out_valid, required 0", seen); end
        $display("[%0t] test_reset_mid done", $time);
    endtask

    task automatic test_streaming();
        int c3;
        int c0;
        int low;
        do_reset();
        out_ready = '1;
        low       = 0;
        c3        = out_cnt[3];
        c0        = out_cnt[0];
        for (int s = 0; s < 20; s++) begin
            tx_q[1].push_back(mk(1, s, 3));
            tx_q[2].push_back(mk(2, s, 0));
        end
        repeat (25) begin
            cycle();
            if (in_valid[1] && !in_ready[1]) low++;
            if (in_valid[2] && !in_ready[2]) low++;
        end
        n_cmp++; if (out_cnt[3] - c3 != 20) begin n_err++; $display("FAIL stream_out3: %0d flits, required 20", out_cnt[3] - c3); end
        n_cmp++; if (out_cnt[0] - c0 != 20) begin n_err++; $display("FAIL stream_out0: %0d flits, required 20", out_cnt[0] - c0); end
        n_cmp++; if (low != 0) begin n_err++; $display("FAIL stream_ready: %0d stalls, required 0", low); end
        drain("stream");
        $display("[%0t] test_streaming done", $time);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '1;
        test_reset();
        test_single();
        test_contention();
        test_uturn();
        test_backpressure();
        test_reset_mid();
        test_streaming();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
